seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 147 ++++++++++++++
 tb/tb_seg_scan_decoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Scanned 7-segment bus decoder: synchronizes the multiplexed sel/seg_led bus,
// waits for a stable pattern, and captures one hex digit per selected position.
//
// state | meaning
// TRACK | pattern changed recently; counting consecutive identical samples
// HOLD  | current pattern already evaluated; wait for it to change
module seg_scan_decoder #(
    parameter int          STABLE_CYCLES = 4,
    parameter logic [25:0] TIMEOUT       = 26'd50_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [5:0]  sel,
    input  logic [7:0]  seg_led,
    output logic [23:0] digits,
    output logic [5:0]  valid,
    output logic [5:0]  dp,
    output logic        update,
    output logic [2:0]  update_idx,
    output logic        err
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;

    typedef enum logic {TRACK, HOLD} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [5:0]     sel_s1, sel_s2;
    logic [7:0]     seg_s1, seg_s2;
    logic [13:0]    prev;
    logic [25:0]    age [6];

    logic [13:0]    cur;
    logic           same;
    logic [2:0]     low_cnt;
    logic [2:0]     idx;
    logic [4:0]     dec;

    // {legal, nibble} for a 7-bit active-low g..a pattern
    function automatic logic [4:0] decode(input logic [6:0] c);
        case (c)
            7'h40:   decode = 5'h10;
            7'h79:   decode = 5'h11;
            7'h24:   decode = 5'h12;
            7'h30:   decode = 5'h13;
            7'h19:   decode = 5'h14;
            7'h12:   decode = 5'h15;
            7'h02:   decode = 5'h16;
            7'h78:   decode = 5'h17;
            7'h00:   decode = 5'h18;
            7'h10:   decode = 5'h19;
            7'h08:   decode = 5'h1A;
            7'h03:   decode = 5'h1B;
            7'h46:   decode = 5'h1C;
            7'h21:   decode = 5'h1D;
            7'h06:   decode = 5'h1E;
            7'h0E:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        cur     = {sel_s2, seg_s2};
        same    = (cur == prev);
        dec     = decode(seg_s2[6:0]);
        low_cnt = 3'd0;
        idx     = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (!sel_s2[i]) begin
                low_cnt = low_cnt + 3'd1;
                idx     = 3'(i);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sel_s1     <= '1;
            sel_s2     <= '1;
            seg_s1     <= '1;
            seg_s2     <= '1;
            prev       <= '1;
            state      <= TRACK;
            cnt        <= '0;
            digits     <= '0;
            valid      <= '0;
            dp         <= '0;
            update     <= 1'b0;
            update_idx <= 3'd0;
            err        <= 1'b0;
            for (int i = 0; i < 6; i++) age[i] <= '0;
        end else begin
            sel_s1 <= sel;
            sel_s2 <= sel_s1;
            seg_s1 <= seg_led;
            seg_s2 <= seg_s1;
            prev   <= cur;
            update <= 1'b0;
            err    <= 1'b0;

            for (int i = 0; i < 6; i++) begin
                if (age[i] != TIMEOUT) age[i] <= age[i] + 26'd1;
                if (age[i] == TIMEOUT - 26'd1) valid[i] <= 1'b0;
            end

            case (state)
                TRACK: begin
                    if (!same) begin
                        cnt <= '0;
                    end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                        // idle or multi-select buses stay in TRACK and are re-ignored
                        if (low_cnt == 3'd1) begin
                            state <= HOLD;
                            cnt   <= '0;
                            if (dec[4]) begin
                                digits[4*idx +: 4] <= dec[3:0];
                                dp[idx]            <= ~seg_s2[7];
                                valid[idx]         <= 1'b1;
                                age[idx]           <= '0;
                                update             <= 1'b1;
                                update_idx         <= idx;
                            end else if (seg_s2[6:0] == 7'h7F) begin
                                valid[idx] <= 1'b0;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (!same) begin
                        state <= TRACK;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= TRACK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus random bus traffic,
// checked every cycle against a sample-history reference model.
module tb_seg_scan_decoder;

    localparam int S  = 4;
    localparam int TO = 16;
    localparam logic [13:0] ONES = 14'h3FFF;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [5:0]  sel;
    logic [7:0]  seg_led;

    logic [23:0] digits,  b_digits;
    logic [5:0]  valid,   b_valid;
    logic [5:0]  dp,      b_dp;
    logic        update,  b_update;
    logic [2:0]  update_idx, b_update_idx;
    logic        err,     b_err;

    seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT(26'd16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sel(sel), .seg_led(seg_led),
        .digits(digits), .valid(valid), .dp(dp), .update(update),
        .update_idx(update_idx), .err(err)
    );

    seg_scan_decoder dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sel(sel), .seg_led(seg_led),
        .digits(b_digits), .valid(b_valid), .dp(b_dp), .update(b_update),
        .update_idx(b_update_idx), .err(b_err)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 3;
    int last_t;

    logic [13:0] hist [0:8191];
    logic [23:0] m_digits;
    logic [5:0]  m_valid, m_dp;
    logic        m_update, m_err;
    logic [2:0]  m_idx;
    int          last_cap [6];

    logic [6:0] code_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [7:0] scan_code [6] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int find_code(input logic [6:0] c);
        for (int n = 0; n < 16; n++) if (code_tab[n] == c) return n;
        return -1;
    endfunction

    // A pattern is evaluated once it has been seen S+1 times in a row, two
    // cycles after the last of those samples (synchronizer delay).
    task automatic model_edge(input logic r, input logic [13:0] v);
        int t;
        t = cyc;
        if (r) begin
            hist[t] = ONES; hist[t-1] = ONES; hist[t-2] = ONES;
            m_digits = '0; m_valid = '0; m_dp = '0;
            m_update = 1'b0; m_err = 1'b0; m_idx = 3'd0;
            for (int i = 0; i < 6; i++) last_cap[i] = t;
        end else begin
            hist[t]  = v;
            m_update = 1'b0;
            m_err    = 1'b0;
            for (int i = 0; i < 6; i++) if (t == last_cap[i] + TO) m_valid[i] = 1'b0;
            if (t >= S + 3) begin
                logic [13:0] p;
                logic [5:0]  lows;
                bit run_ok;
                int d, n;
                p = hist[t-2];
                run_ok = 1'b1;
                for (int k = 1; k <= S; k++) if (hist[t-2-k] != p) run_ok = 1'b0;
                if (hist[t-3-S] == p) run_ok = 1'b0;
                lows = ~p[13:8];
                if (run_ok && $countones(lows) == 1) begin
                    d = 0;
                    for (int i = 0; i < 6; i++) if (lows[i]) d = i;
                    n = find_code(p[6:0]);
                    if (n >= 0) begin
                        m_digits[4*d +: 4] = n[3:0];
                        m_dp[d]     = ~p[7];
                        m_valid[d]  = 1'b1;
                        last_cap[d] = t;
                        m_update    = 1'b1;
                        m_idx       = 3'(d);
                    end else if (p[6:0] == 7'h7F) begin
                        m_valid[d] = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic tick(input logic [5:0] s, input logic [7:0] g, input logic r);
        sel = s; seg_led = g; sys_rst = r;
        @(posedge sys_clk);
        model_edge(r, {s, g});
        #1;
        chk("digits", digits, m_digits);
        chk("valid",  valid,  m_valid);
        chk("dp",     dp,     m_dp);
        chk("update", update, m_update);
        chk("err",    err,    m_err);
        if (m_update) chk("update_idx", update_idx, m_idx);
        last_t = cyc;
        cyc++;
        if (cyc > 8000) begin
            $display("FAIL history_overflow cyc=%0d", cyc);
            $fatal(1);
        end
    endtask

    task automatic scan_all();
        logic [5:0] s;
        for (int i = 0; i < 6; i++) begin
            s = ~(6'(1) << i);
            repeat (8) tick(s, scan_code[i], 1'b0);
        end
    endtask

    int nupd, nerr, upd_t, start, found, c;
    logic [5:0] rs;
    logic [7:0] rg;

    initial begin
        sys_rst = 1'b1; sel = '1; seg_led = '1;
        for (int i = 0; i < 3; i++) hist[i] = ONES;

        // reset state
        tick('1, '1, 1'b1);
        tick('1, '1, 1'b1);
        chk("rst_update_idx", update_idx, 0);
        chk("rst_b_digits", b_digits, 0);

        // single capture and latency
        start = cyc; nupd = 0; upd_t = -1;
        repeat (10) begin
            tick(6'b111011, 8'hA4, 1'b0);
            if (update) begin nupd++; upd_t = last_t; end
        end
        chk("r028_nupd", nupd, 1);
        chk("r028_latency", upd_t - start, S + 2);
        chk("r028_digit", digits[11:8], 4'h2);
        chk("r028_valid", valid, 6'b000100);
        chk("r028_dp", dp[2], 1'b0);

        // capture with dp lit, then blank clears valid only
        repeat (8) tick(6'b111110, 8'h0E, 1'b0);
        chk("r029_digit", digits[3:0], 4'hF);
        chk("r029_dp", dp[0], 1'b1);
        chk("r029_valid", valid[0], 1'b1);
        repeat (8) tick(6'b111110, 8'hFF, 1'b0);
        chk("r029_blank_valid", valid[0], 1'b0);
        chk("r029_blank_digit", digits[3:0], 4'hF);

        // glitching segments never reach the stability count
        nupd = 0; nerr = 0;
        for (int k = 0; k < 16; k++) begin
            tick(6'b011111, (k % 4 < 2) ? 8'h92 : 8'h99, 1'b0);
            nupd += int'(update); nerr += int'(err);
        end
        chk("r030_glitch_upd", nupd, 0);
        chk("r030_glitch_err", nerr, 0);
        nupd = 0;
        repeat (8) begin tick(6'b011111, 8'h99, 1'b0); nupd += int'(update); end
        chk("r030_held_upd", nupd, 1);
        chk("r030_digit", digits[23:20], 4'h4);

        // multi-select patterns ignored, illegal code flags err
        nupd = 0; nerr = 0;
        repeat (8) begin tick(6'b000000, 8'hC0, 1'b0); nupd += int'(update); nerr += int'(err); end
        repeat (8) begin tick(6'b111100, 8'hC0, 1'b0); nupd += int'(update); nerr += int'(err); end
        chk("r031_multi_upd", nupd, 0);
        chk("r031_multi_err", nerr, 0);
        nupd = 0; nerr = 0;
        repeat (8) begin tick(6'b111101, 8'h55, 1'b0); nupd += int'(update); nerr += int'(err); end
        chk("r031_illegal_err", nerr, 1);
        chk("r031_illegal_upd", nupd, 0);
        chk("r031_digit1", digits[7:4], 4'h0);

        // timeout and capture-wins-over-timeout
        tick('1, '1, 1'b1);
        found = 0; c = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            tick(6'b110111, 8'hB0, 1'b0);
            if (update) begin found = 1; c = last_t; end
        end
        chk("r032_cap1", found, 1);
        for (int k = 1; k <= 16; k++) begin
            tick('1, '1, 1'b0);
            if (k == 15) chk("r032_before_to", valid[3], 1'b1);
            if (k == 16) chk("r032_at_to", valid[3], 1'b0);
        end
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            tick(6'b110111, 8'hB0, 1'b0);
            if (update) begin found = 1; c = last_t; end
        end
        chk("r032_cap2", found, 1);
        repeat (9) tick('1, '1, 1'b0);
        repeat (7) tick(6'b110111, 8'hB0, 1'b0);
        chk("r032_recap_edge", last_t - c, 16);
        chk("r032_recap_upd", update, 1'b1);
        chk("r032_recap_valid", valid[3], 1'b1);

        // six-digit scan, mid-scan reset, rebuild
        tick('1, '1, 1'b1);
        scan_all();
        chk("r033_b_digits", b_digits, 24'h543210);
        chk("r033_b_valid", b_valid, 6'h3F);
        chk("r033_b_dp", b_dp, 6'h00);
        chk("r033_digits", digits, 24'h543210);
        for (int i = 0; i < 3; i++) repeat (8) tick(~(6'(1) << i), scan_code[i], 1'b0);
        repeat (3) tick(6'b110111, 8'hB0, 1'b0);
        tick(6'b110111, 8'hB0, 1'b1);
        chk("r033_rst_digits", b_digits, 0);
        chk("r033_rst_valid", b_valid, 0);
        chk("r033_rst_dp", b_dp, 0);
        chk("r033_rst_flags", {b_update, b_err, b_update_idx}, 0);
        start = cyc; nupd = 0; upd_t = -1;
        repeat (8) begin
            tick(6'b110111, 8'hB0, 1'b0);
            if (b_update) begin nupd++; upd_t = last_t; end
        end
        chk("r027_nupd", nupd, 1);
        chk("r027_latency", upd_t - start, S + 2);
        scan_all();
        chk("r033_rebuild_digits", b_digits, 24'h543210);
        chk("r033_rebuild_valid", b_valid, 6'h3F);

        // random traffic against the model
        for (int n = 0; n < 220; n++) begin
            case ($urandom_range(0, 9))
                0:       rs = 6'b111111;
                1:       rs = 6'b000000;
                2:       rs = 6'($urandom);
                default: rs = ~(6'(1) << $urandom_range(0, 5));
            endcase
            case ($urandom_range(0, 9))
                0:       rg = {1'($urandom), 7'h7F};
                1:       rg = 8'($urandom);
                default: rg = {1'($urandom), code_tab[$urandom_range(0, 15)]};
            endcase
            if ($urandom_range(0, 39) == 0) tick(rs, rg, 1'b1);
            repeat ($urandom_range(1, 10)) tick(rs, rg, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
